serial_add_deser: RTL

//   Bit-serial add/subtract receiver. Two LSB-first operand bit streams arrive

---
 rtl/serial_add_deser.sv | 139 +++++++++++++
 1 files changed

// File: rtl/serial_add_deser.sv
// Bit-serial add/subtract receiver: LSB-first operand streams in, parallel
// result out on a valid/ready handshake.
module serial_add_deser #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bit_valid,
    input  logic             sof,
    input  logic             a_bit,
    input  logic             b_bit,
    input  logic             sub,
    input  logic             sum_ready,
    output logic             sum_valid,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy,
    output logic             frame_err
);

    localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             carry_q;
    logic             carry_d;
    logic             sub_l_q;
    logic             sub_l_d;
    logic [WIDTH-1:0] sum_d;
    logic             cout_d;
    logic             sum_valid_d;
    logic             frame_err_d;
    logic             busy_d;

    logic             start_beat;
    logic             take_beat;
    logic             b_eff;
    logic             c_in;
    logic             s_bit;
    logic             c_next;

    // Register stage: FSM state, datapath and all outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            carry_q   <= 1'b0;
            sub_l_q   <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            sum_valid <= 1'b0;
            busy      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            carry_q   <= carry_d;
            sub_l_q   <= sub_l_d;
            sum       <= sum_d;
            cout      <= cout_d;
            sum_valid <= sum_valid_d;
            busy      <= busy_d;
            frame_err <= frame_err_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bit_valid && sof) state_d = RECV;
            end
            RECV: begin
                if (bit_valid && !sof && (cnt_q == LAST_CNT)) state_d = HOLD;
            end
            HOLD: begin
                if (sum_ready) state_d = (bit_valid && sof) ? RECV : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Bit 0 of a frame may arrive in IDLE, mid-frame (restart) or with the HOLD handshake.
    always_comb begin
        start_beat = bit_valid && sof &&
                     ((state_q == IDLE) || (state_q == RECV) ||
                      ((state_q == HOLD) && sum_ready));
        take_beat  = start_beat || ((state_q == RECV) && bit_valid && !sof);
        b_eff      = b_bit ^ (start_beat ? sub : sub_l_q);
        c_in       = start_beat ? sub : carry_q;
        s_bit      = a_bit ^ b_eff ^ c_in;
        c_next     = (a_bit & b_eff) | (a_bit & c_in) | (b_eff & c_in);
    end

    // Output / datapath next values.
    always_comb begin
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        sub_l_d     = sub_l_q;
        sum_d       = sum;
        cout_d      = cout;
        sum_valid_d = sum_valid;
        frame_err_d = 1'b0;
        busy_d      = (state_d != IDLE);

        if (take_beat) begin
            sum_d   = {s_bit, sum[WIDTH-1:1]};
            carry_d = c_next;
        end

        if (start_beat) begin
            sub_l_d     = sub;
            cnt_d       = CNT_W'(1);
            sum_valid_d = 1'b0;
            frame_err_d = (state_q == RECV);
        end else if (take_beat) begin
            if (cnt_q == LAST_CNT) begin
                cnt_d       = '0;
                sum_valid_d = 1'b1;
                cout_d      = c_next;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if ((state_q == HOLD) && sum_ready) begin
            sum_valid_d = 1'b0;
        end
    end

endmodule
